// File: rtl/rv32_pkg.sv
// rv32_pkg: definitions shared by the RV32M multiply/divide slice.
//   - funct3 encodings for the eight RV32M operations
//   - FSM state enum used by rv32m_muldiv_unit
//   - XLEN_DEFAULT (operand width) and MUL_LAT_MAX (largest multiply latency)
package rv32_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int MUL_LAT_MAX  = 8;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Division family when bit 2 is set; bit 0 selects the unsigned variants.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// rv32m_muldiv_unit_if: request/response bundle of the RV32M unit.
//   master (requester): drives in_valid/in_funct3/in_rs1/in_rs2/in_rd, kill, out_ready
//   slave  (unit)     : drives in_ready, out_valid/out_result/out_rd/out_illegal, busy
interface rv32m_muldiv_unit_if
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [4:0]      in_rd;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            out_illegal;
  logic            busy;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_rd, kill, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal, busy
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_rd, kill, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal, busy
  );

endinterface

// File: rtl/rv32m_div_iter.sv
// rv32m_div_iter: unsigned radix-2 restoring divider, one quotient bit per clock.
//   clk, rst        : clock, synchronous active-high reset
//   start           : load dividend/divisor magnitudes and begin iterating
//   flush           : abandon the current division
//   dividend,divisor: unsigned operands (sampled on start)
//   done            : quotient/remainder valid; set XLEN edges after start, held until next start/flush
//   quotient,remainder
module rv32m_div_iter
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int              CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);

  logic            active_q, active_d, done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN:0]   shifted_s;
  logic            sub_ok_s;
  logic [XLEN-1:0] diff_s;

  // One restoring step: shift the next dividend bit (quo MSB) into the partial remainder.
  always_comb begin
    shifted_s = {rem_q, quo_q[XLEN-1]};
    sub_ok_s  = (shifted_s >= {1'b0, dvs_q});
    // Only used when sub_ok_s, where the true difference is below the divisor.
    diff_s    = shifted_s[XLEN-1:0] - dvs_q;
    active_d  = active_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    if (flush) begin
      active_d = 1'b0;
      done_d   = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      done_d   = 1'b0;
      cnt_d    = {CW{1'b0}};
      rem_d    = {XLEN{1'b0}};
      quo_d    = dividend;
      dvs_d    = divisor;
    end else if (active_q) begin
      if (sub_ok_s) begin
        rem_d = diff_s;
      end else begin
        rem_d = shifted_s[XLEN-1:0];
      end
      quo_d = {quo_q[XLEN-2:0], sub_ok_s};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        active_d = 1'b1;
        done_d   = 1'b0;
      end
    end else begin
      active_d = active_q;
    end
  end

  // Iteration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      quo_q    <= {XLEN{1'b0}};
      dvs_q    <= {XLEN{1'b0}};
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: RV32M multiply/divide unit with a four-state FSM (IDLE/MUL/DIV/DONE).
//   clk, rst : clock, synchronous active-high reset
//   bus      : rv32m_muldiv_unit_if.slave (request handshake, kill, result handshake, busy)
// Multiplies return MUL_LAT edges after accept. Divides use rv32m_div_iter (XLEN+1 edges),
// with divide-by-zero and signed overflow resolved in 1 edge.
// Build option MULDIV_DIV_EN: when defined the divider is built and out_illegal is always 0;
// when undefined division ops complete in 1 edge with result 0 and out_illegal=1.
module rv32m_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  rv32m_muldiv_unit_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("rv32m_muldiv_unit: XLEN must be 32");
  end
  if ((MUL_LAT < 1) || (MUL_LAT > MUL_LAT_MAX)) begin : g_lat_check
    $error("rv32m_muldiv_unit: MUL_LAT must be within 1..8");
  end

  localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

  state_e            state_q, state_d;
  logic              accept_s;
  logic [2:0]        cnt_q, cnt_d, f3_q, f3_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, result_q, result_d;
  logic [4:0]        rd_q, rd_d;
  logic              illegal_q, illegal_d;
  logic [2*XLEN-1:0] mul_a_s, mul_b_s, prod_s;
  logic [XLEN-1:0]   mul_res_s;
  logic              div_fin_s;
  logic [XLEN-1:0]   div_res_s;

  assign accept_s = bus.in_valid && (state_q == ST_IDLE) && !bus.kill;

  // Sign-extend per op so one 2*XLEN-bit product serves all four multiply variants.
  always_comb begin
    if ((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) begin
      mul_a_s = {{XLEN{rs1_q[XLEN-1]}}, rs1_q};
    end else begin
      mul_a_s = {{XLEN{1'b0}}, rs1_q};
    end
    if (f3_q == F3_MULH) begin
      mul_b_s = {{XLEN{rs2_q[XLEN-1]}}, rs2_q};
    end else begin
      mul_b_s = {{XLEN{1'b0}}, rs2_q};
    end
    prod_s = mul_a_s * mul_b_s;
    if (f3_q == F3_MUL) begin
      mul_res_s = prod_s[XLEN-1:0];
    end else begin
      mul_res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_DIV_EN
  localparam logic            DIV_ABSENT = 1'b0;
  localparam logic [XLEN-1:0] SMIN       = {1'b1, {(XLEN-1){1'b0}}};

  logic            in_signed_s, in_zero_s, in_ovf_s, div_start_s, div_done_s;
  logic            fast_q, fast_d;
  logic [XLEN-1:0] mag_a_s, mag_b_s, div_quo_s, div_rem_s, quo_s, rem_s;

  // Classify the incoming request and hand operand magnitudes to the iterator on accept.
  always_comb begin
    in_signed_s = !bus.in_funct3[0];
    in_zero_s   = (bus.in_rs2 == {XLEN{1'b0}});
    in_ovf_s    = in_signed_s && (bus.in_rs1 == SMIN) && (bus.in_rs2 == {XLEN{1'b1}});
    if (in_signed_s && bus.in_rs1[XLEN-1]) begin
      mag_a_s = {XLEN{1'b0}} - bus.in_rs1;
    end else begin
      mag_a_s = bus.in_rs1;
    end
    if (in_signed_s && bus.in_rs2[XLEN-1]) begin
      mag_b_s = {XLEN{1'b0}} - bus.in_rs2;
    end else begin
      mag_b_s = bus.in_rs2;
    end
    div_start_s = accept_s && f3_is_div(bus.in_funct3) && !in_zero_s && !in_ovf_s;
  end

  // Fast-path flag: the op resolves without iterating.
  always_comb begin
    if (bus.kill) begin
      fast_d = 1'b0;
    end else if (accept_s) begin
      fast_d = in_zero_s || in_ovf_s;
    end else begin
      fast_d = fast_q;
    end
  end

  // Fast-path flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fast_q <= 1'b0;
    end else begin
      fast_q <= fast_d;
    end
  end

  rv32m_div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .flush     (bus.kill),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Restore signs and apply the fast-path results (zero divisor, then signed overflow).
  always_comb begin
    if (rs2_q == {XLEN{1'b0}}) begin
      quo_s = {XLEN{1'b1}};
      rem_s = rs1_q;
    end else if (fast_q) begin
      quo_s = rs1_q;
      rem_s = {XLEN{1'b0}};
    end else begin
      if (!f3_q[0] && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1])) begin
        quo_s = {XLEN{1'b0}} - div_quo_s;
      end else begin
        quo_s = div_quo_s;
      end
      if (!f3_q[0] && rs1_q[XLEN-1]) begin
        rem_s = {XLEN{1'b0}} - div_rem_s;
      end else begin
        rem_s = div_rem_s;
      end
    end
    if (f3_q[1]) begin
      div_res_s = rem_s;
    end else begin
      div_res_s = quo_s;
    end
    div_fin_s = fast_q || div_done_s;
  end
`else
  localparam logic DIV_ABSENT = 1'b1;

  assign div_fin_s = 1'b1;
  assign div_res_s = {XLEN{1'b0}};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; kill overrides accept and consumption.
  always_comb begin
    if (bus.kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = f3_is_div(bus.in_funct3) ? ST_DIV : ST_MUL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL:  state_d = (cnt_q == MUL_LAST) ? ST_DONE : ST_MUL;
        ST_DIV:  state_d = div_fin_s ? ST_DONE : ST_DIV;
        ST_DONE: state_d = bus.out_ready ? ST_IDLE : ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) && !bus.kill;
    bus.out_valid = (state_q == ST_DONE);
    bus.busy      = (state_q != ST_IDLE);
  end

  // Datapath next values: latch on accept, capture the result when leaving MUL/DIV.
  always_comb begin
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (bus.kill) begin
      cnt_d     = 3'd0;
      illegal_d = 1'b0;
    end else if (accept_s) begin
      cnt_d     = 3'd0;
      f3_d      = bus.in_funct3;
      rs1_d     = bus.in_rs1;
      rs2_d     = bus.in_rs2;
      rd_d      = bus.in_rd;
      illegal_d = DIV_ABSENT && f3_is_div(bus.in_funct3);
    end else begin
      case (state_q)
        ST_MUL: begin
          if (cnt_q == MUL_LAST) begin
            result_d = mul_res_s;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_DIV: begin
          if (div_fin_s) begin
            result_d = div_res_s;
          end else begin
            result_d = result_q;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            illegal_d = 1'b0;
          end else begin
            illegal_d = illegal_q;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 3'd0;
      f3_q      <= 3'd0;
      rs1_q     <= {XLEN{1'b0}};
      rs2_q     <= {XLEN{1'b0}};
      rd_q      <= 5'd0;
      result_q  <= {XLEN{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_result  = result_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb_rv32m_muldiv_unit: randomized and directed self-checking bench for rv32m_muldiv_unit.
module tb_rv32m_muldiv_unit;
  import rv32_pkg::*;

  localparam int MUL_LAT = 4;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  rv32m_muldiv_unit_if #(.XLEN(32)) bus ();

  rv32m_muldiv_unit #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural RV32M results from plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    int          q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (f3)
      3'b000: begin p = sa * sb; r = p[31:0];  end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      default: begin
        if (!DIV_EN) r = 32'd0;
        else if (b == 32'd0) r = f3[1] ? a : 32'hFFFF_FFFF;
        else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = f3[1] ? 32'd0 : a;
        else if (!f3[0]) begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r = f3[1] ? m : q;
        end else r = f3[1] ? (a % b) : (a / b);
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (!DIV_EN) return 1;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drive a request and step through its accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    if (bus.in_ready !== 1'b1) begin
      bus.kill = 1'b1;
      @(posedge clk); #1;
      bus.kill = 1'b0;
    end
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f3;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rd     = rd;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  // Count edges after accept until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output logic [31:0] res, output logic [4:0] rd_o, output logic ill);
    issue(f3, a, b, rd);
    wait_valid(lat);
    res  = bus.out_result;
    rd_o = bus.out_rd;
    ill  = bus.out_illegal;
    consume();
  endtask

  task automatic test_reset();
    int seen;
    int lat;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.out_result !== 32'd0) $display("FAIL reset_out_result: got %h want 0", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_rd !== 5'd0) $display("FAIL reset_out_rd: got %0d want 0", bus.out_rd); else n_pass++;
    n_checks++; if (bus.out_illegal !== 1'b0) $display("FAIL reset_out_illegal: got %b want 0", bus.out_illegal); else n_pass++;
    rst = 1'b0;
    // Reset in the middle of a multiply abandons it.
    issue(F3_MUL, 32'd6, 32'd7, 5'd5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_midop_busy: got %b want 0", bus.busy); else n_pass++;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) $display("FAIL reset_midop_no_result: got %0d valid cycles want 0", seen); else n_pass++;
    n_checks++; if (bus.out_result !== 32'd0) $display("FAIL reset_midop_result: got %h want 0", bus.out_result); else n_pass++;
    lat = 0;
  endtask

  task automatic test_mul_directed();
    logic [2:0]  f3s  [4] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU};
    logic [31:0] as   [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] exps [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat; logic [31:0] res; logic [4:0] rd_o; logic ill;
    for (int i = 0; i < 4; i++) begin
      do_op(f3s[i], as[i], bs[i], 5'(9 + i), lat, res, rd_o, ill);
      n_checks++; if (res !== exps[i]) $display("FAIL mul_dir_result[%0d]: got %h want %h", i, res, exps[i]); else n_pass++;
      n_checks++; if (lat != MUL_LAT) $display("FAIL mul_dir_latency[%0d]: got %0d want %0d", i, lat, MUL_LAT); else n_pass++;
      n_checks++; if (rd_o !== 5'(9 + i)) $display("FAIL mul_dir_rd[%0d]: got %0d want %0d", i, rd_o, 9 + i); else n_pass++;
    end
  endtask

  task automatic test_div_directed();
    logic [2:0]  f3s  [8] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIVU, F3_REM, F3_DIV, F3_REM};
    logic [31:0] as   [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs   [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          lats [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
    int lat; logic [31:0] res; logic [4:0] rd_o; logic ill;
    logic [31:0] want_res; int want_lat; logic want_ill;
    for (int i = 0; i < 8; i++) begin
      want_res = DIV_EN ? exps[i] : 32'd0;
      want_lat = DIV_EN ? lats[i] : 1;
      want_ill = !DIV_EN;
      do_op(f3s[i], as[i], bs[i], 5'(20 + i), lat, res, rd_o, ill);
      n_checks++; if (res !== want_res) $display("FAIL div_dir_result[%0d]: got %h want %h", i, res, want_res); else n_pass++;
      n_checks++; if (lat != want_lat) $display("FAIL div_dir_latency[%0d]: got %0d want %0d", i, lat, want_lat); else n_pass++;
      n_checks++; if (ill !== want_ill) $display("FAIL div_dir_illegal[%0d]: got %b want %b", i, ill, want_ill); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [2:0] f3; logic [31:0] a, b; logic [4:0] rd;
    int lat; logic [31:0] res; logic [4:0] rd_o; logic ill;
    int sel;
    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) rd = 5'd0;
      do_op(f3, a, b, rd, lat, res, rd_o, ill);
      n_checks++; if (res !== ref_result(f3, a, b)) $display("FAIL rand_result[%0d] f3=%0d a=%h b=%h: got %h want %h", i, f3, a, b, res, ref_result(f3, a, b)); else n_pass++;
      n_checks++; if (lat != ref_lat(f3, a, b)) $display("FAIL rand_latency[%0d] f3=%0d: got %0d want %0d", i, f3, lat, ref_lat(f3, a, b)); else n_pass++;
      n_checks++; if (rd_o !== rd) $display("FAIL rand_rd[%0d]: got %0d want %0d", i, rd_o, rd); else n_pass++;
      n_checks++; if (ill !== (f3[2] && !DIV_EN)) $display("FAIL rand_illegal[%0d]: got %b want %b", i, ill, f3[2] && !DIV_EN); else n_pass++;
    end
  endtask

  task automatic test_hold();
    logic [31:0] a, b, want;
    int lat;
    a = $urandom; b = $urandom;
    want = ref_result(F3_MULHU, a, b);
    issue(F3_MULHU, a, b, 5'd17);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== want || bus.out_rd !== 5'd17 || bus.in_ready !== 1'b0)
        $display("FAIL hold_cycle[%0d]: valid=%b result=%h rd=%0d in_ready=%b want 1/%h/17/0", i, bus.out_valid, bus.out_result, bus.out_rd, bus.in_ready, want);
      else n_pass++;
      @(posedge clk); #1;
    end
    consume();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL hold_release: in_ready=%b busy=%b valid=%b want 1/0/0", bus.in_ready, bus.busy, bus.out_valid); else n_pass++;
  endtask

  task automatic test_kill();
    int seen, lat, kill_at;
    logic [31:0] res; logic [4:0] rd_o; logic ill;
    kill_at = DIV_EN ? 10 : 2;
    if (DIV_EN) issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
    else issue(F3_MUL, 32'd5, 32'd5, 5'd3);
    repeat (kill_at) begin @(posedge clk); #1; end
    bus.kill = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL kill_in_ready_low: got %b want 0", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL kill_to_idle: busy=%b valid=%b in_ready=%b want 0/0/1", bus.busy, bus.out_valid, bus.in_ready); else n_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) $display("FAIL kill_no_result: got %0d valid cycles want 0", seen); else n_pass++;
    do_op(F3_MUL, 32'd3, 32'd3, 5'd4, lat, res, rd_o, ill);
    n_checks++; if (res !== 32'd9 || lat != MUL_LAT) $display("FAIL kill_then_mul: got %h lat %0d want 9 lat %0d", res, lat, MUL_LAT); else n_pass++;
    // kill wins over a same-cycle accept
    bus.in_valid = 1'b1; bus.in_funct3 = F3_MUL; bus.in_rs1 = 32'd2; bus.in_rs2 = 32'd2; bus.in_rd = 5'd1;
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL kill_over_accept: busy=%b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int lat;
    issue(F3_MUL, 32'd11, 32'd13, 5'd6);
    wait_valid(lat);
    a = $urandom; b = $urandom;
    bus.in_valid = 1'b1; bus.in_funct3 = F3_MULH; bus.in_rs1 = a; bus.in_rs2 = b; bus.in_rd = 5'd7;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_no_ready_on_consume: got %b want 0", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL b2b_idle_after_consume: busy=%b valid=%b want 0/0", bus.busy, bus.out_valid); else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept_next: busy=%b want 1", bus.busy); else n_pass++;
    wait_valid(lat);
    n_checks++; if (bus.out_result !== ref_result(F3_MULH, a, b) || bus.out_rd !== 5'd7 || lat != MUL_LAT)
      $display("FAIL b2b_second_result: got %h rd %0d lat %0d want %h rd 7 lat %0d", bus.out_result, bus.out_rd, lat, ref_result(F3_MULH, a, b), MUL_LAT);
    else n_pass++;
    consume();
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_funct3 = 3'd0; bus.in_rs1 = 32'd0; bus.in_rs2 = 32'd0;
    bus.in_rd = 5'd0; bus.kill = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_random();
    test_hold();
    test_kill();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
